stream_merge4: RTL and testbench

STREAM_MERGE4 -- requirements
Module: stream_merge4

---
 rtl/stream_merge4.sv | 128 ++++++++++++
 tb/tb_stream_merge4.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_merge4.sv
// Four-input stream merger into a single registered output slot, round-robin or fixed-priority.
// Optional source-index output out_src is enabled by defining STREAM_MERGE4_SRC_ID_EN.
module stream_merge4 #(
    parameter int ARB_RR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         in0_data,
    input  logic [15:0]         in1_data,
    input  logic [15:0]         in2_data,
    input  logic [15:0]         in3_data,
    input  logic signed [12:0]  in0_data2,
    input  logic signed [12:0]  in1_data2,
    input  logic signed [12:0]  in2_data2,
    input  logic signed [12:0]  in3_data2,
    input  logic                in0_valid,
    input  logic                in1_valid,
    input  logic                in2_valid,
    input  logic                in3_valid,
    output logic                in0_ready,
    output logic                in1_ready,
    output logic                in2_ready,
    output logic                in3_ready,
    output logic [15:0]         out_data,
    output logic signed [12:0]  out_data2,
    output logic                out_valid,
    input  logic                out_ready
`ifdef STREAM_MERGE4_SRC_ID_EN
    ,
    output logic [1:0]          out_src
`endif
);

    localparam int DATA_W  = 16;
    localparam int DATA2_W = 13;

    logic [3:0]                w_valid;
    logic [1:0]                w_gnt_idx;
    logic                      w_gnt_any;
    logic                      w_free;
    logic                      w_in_xfer;
    logic [DATA_W-1:0]         w_sel_data;
    logic signed [DATA2_W-1:0] w_sel_data2;

    logic [1:0]                r_ptr;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic signed [DATA2_W-1:0] r_out_data2;
`ifdef STREAM_MERGE4_SRC_ID_EN
    logic [1:0]                r_out_src;
`endif

    assign w_valid = {in3_valid, in2_valid, in1_valid, in0_valid};

    // Search starts just after the last granted index in round-robin mode, at in0 otherwise.
    always_comb begin
        logic [1:0] v_cand;
        w_gnt_idx = 2'd0;
        w_gnt_any = 1'b0;
        v_cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v_cand = (ARB_RR != 0) ? 2'(r_ptr + 2'(i + 1)) : 2'(i);
            if (!w_gnt_any && w_valid[v_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = v_cand;
            end
        end
    end

    always_comb begin
        w_sel_data  = in0_data;
        w_sel_data2 = in0_data2;
        case (w_gnt_idx)
            2'd1: begin
                w_sel_data  = in1_data;
                w_sel_data2 = in1_data2;
            end
            2'd2: begin
                w_sel_data  = in2_data;
                w_sel_data2 = in2_data2;
            end
            2'd3: begin
                w_sel_data  = in3_data;
                w_sel_data2 = in3_data2;
            end
            default: ;
        endcase
    end

    // Gating with rst_n keeps every ready low while reset is asserted.
    assign w_free    = !r_out_valid || out_ready;
    assign w_in_xfer = w_gnt_any && w_free && rst_n;

    assign in0_ready = w_in_xfer && (w_gnt_idx == 2'd0);
    assign in1_ready = w_in_xfer && (w_gnt_idx == 2'd1);
    assign in2_ready = w_in_xfer && (w_gnt_idx == 2'd2);
    assign in3_ready = w_in_xfer && (w_gnt_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_data2 <= '0;
            r_ptr       <= 2'd3;
`ifdef STREAM_MERGE4_SRC_ID_EN
            r_out_src   <= 2'd0;
`endif
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_data2 <= w_sel_data2;
            r_ptr       <= w_gnt_idx;
`ifdef STREAM_MERGE4_SRC_ID_EN
            r_out_src   <= w_gnt_idx;
`endif
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_data2 = r_out_data2;
`ifdef STREAM_MERGE4_SRC_ID_EN
    assign out_src   = r_out_src;
`endif

endmodule

// File: tb/tb_stream_merge4.sv
// Bench for stream_merge4: a round-robin and a fixed-priority instance share one stimulus
// and are compared against a transfer-level reference model. Honours STREAM_MERGE4_SRC_ID_EN.
module tb_stream_merge4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [15:0]         d[4];
    logic signed [12:0]  e[4];
    logic [3:0]          v;
    logic                ordy;

    logic [3:0]          rr_rdy, fp_rdy;
    logic [15:0]         rr_od, fp_od;
    logic signed [12:0]  rr_od2, fp_od2;
    logic                rr_ov, fp_ov;
`ifdef STREAM_MERGE4_SRC_ID_EN
    logic [1:0]          rr_src, fp_src;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    stream_merge4 #(.ARB_RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in0_data(d[0]), .in1_data(d[1]), .in2_data(d[2]), .in3_data(d[3]),
        .in0_data2(e[0]), .in1_data2(e[1]), .in2_data2(e[2]), .in3_data2(e[3]),
        .in0_valid(v[0]), .in1_valid(v[1]), .in2_valid(v[2]), .in3_valid(v[3]),
        .in0_ready(rr_rdy[0]), .in1_ready(rr_rdy[1]), .in2_ready(rr_rdy[2]), .in3_ready(rr_rdy[3]),
        .out_data(rr_od), .out_data2(rr_od2), .out_valid(rr_ov), .out_ready(ordy)
`ifdef STREAM_MERGE4_SRC_ID_EN
        , .out_src(rr_src)
`endif
    );

    stream_merge4 #(.ARB_RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in0_data(d[0]), .in1_data(d[1]), .in2_data(d[2]), .in3_data(d[3]),
        .in0_data2(e[0]), .in1_data2(e[1]), .in2_data2(e[2]), .in3_data2(e[3]),
        .in0_valid(v[0]), .in1_valid(v[1]), .in2_valid(v[2]), .in3_valid(v[3]),
        .in0_ready(fp_rdy[0]), .in1_ready(fp_rdy[1]), .in2_ready(fp_rdy[2]), .in3_ready(fp_rdy[3]),
        .out_data(fp_od), .out_data2(fp_od2), .out_valid(fp_ov), .out_ready(ordy)
`ifdef STREAM_MERGE4_SRC_ID_EN
        , .out_src(fp_src)
`endif
    );

    // Reference model, index 0 = round-robin instance, 1 = fixed priority.
    int                 m_ptr[2];
    logic               m_ov[2];
    logic [15:0]        m_od[2];
    logic signed [12:0] m_od2[2];

    function automatic int m_grant(int m);
        int k;
        for (int off = 1; off <= 4; off++) begin
            k = (m == 0) ? (m_ptr[m] + off) % 4 : off - 1;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_rdy(int m);
        int g;
        g = m_grant(m);
        if (!rst_n || !(!m_ov[m] || ordy) || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    function automatic logic [33:0] m_pack(int m);
        return {m_ov[m], m_od[m], m_od2[m], m_rdy(m)};
    endfunction

    wire [33:0] obs_rr = {rr_ov, rr_od, rr_od2, rr_rdy};
    wire [33:0] obs_fp = {fp_ov, fp_od, fp_od2, fp_rdy};

    always @(posedge clk) begin : model
        for (int m = 0; m < 2; m++) begin
            int g;
            g = m_grant(m);
            if (!rst_n) begin
                m_ov[m]  = 1'b0;
                m_od[m]  = '0;
                m_od2[m] = '0;
                m_ptr[m] = 3;
            end else if (g >= 0 && (!m_ov[m] || ordy)) begin
                m_ov[m]  = 1'b1;
                m_od[m]  = d[g];
                m_od2[m] = e[g];
                m_ptr[m] = g;
            end else if (m_ov[m] && ordy) begin
                m_ov[m] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v = 4'hF; ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin d[k] = 16'hFFFF; e[k] = -13'sd1; end
        tick(); tick();
        @(negedge clk);
        n_tests++; if (rr_ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rr_ov); end
        n_tests++; if (rr_od !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", rr_od); end
        n_tests++; if (rr_od2 !== 13'sd0) begin n_fail++; $display("FAIL reset_data2: got %0d expected 0", rr_od2); end
        n_tests++; if (rr_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy_rr: got %b expected 0000", rr_rdy); end
        n_tests++; if (fp_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy_fp: got %b expected 0000", fp_rdy); end
    endtask

    task automatic test_priority();
        rst_n = 1'b0; v = 4'b0000; tick();
        rst_n = 1'b1; ordy = 1'b1; v = 4'b0101;
        d[0] = 16'h1234; e[0] = 13'sd7;
        d[2] = 16'hBEEF; e[2] = -13'sd5;
        @(negedge clk);
        n_tests++; if (rr_rdy !== 4'b0001) begin n_fail++; $display("FAIL prio_first_rr: got %b expected 0001", rr_rdy); end
        n_tests++; if (fp_rdy !== 4'b0001) begin n_fail++; $display("FAIL prio_first_fp: got %b expected 0001", fp_rdy); end
        tick();
        @(negedge clk);
        n_tests++; if (rr_ov !== 1'b1 || rr_od !== 16'h1234) begin n_fail++; $display("FAIL prio_beat0: got %b/%h expected 1/1234", rr_ov, rr_od); end
        n_tests++; if (rr_rdy !== 4'b0100) begin n_fail++; $display("FAIL prio_second_rr: got %b expected 0100", rr_rdy); end
        n_tests++; if (fp_rdy !== 4'b0001) begin n_fail++; $display("FAIL prio_second_fp: got %b expected 0001", fp_rdy); end
        tick();
        @(negedge clk);
        n_tests++; if (rr_od !== 16'hBEEF) begin n_fail++; $display("FAIL prio_beef_data: got %h expected beef", rr_od); end
        n_tests++; if (rr_od2 !== -13'sd5) begin n_fail++; $display("FAIL prio_beef_data2: got %0d expected -5", rr_od2); end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; v = 4'hF; ordy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) begin
                d[k] = 16'(c * 16 + k);
                e[k] = 13'(-(c * 4 + k));
            end
            @(negedge clk);
            n_tests++; if (rr_rdy !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, rr_rdy, 4'(1 << (c % 4))); end
            n_tests++; if (fp_rdy !== 4'b0001) begin n_fail++; $display("FAIL fp_grant c=%0d: got %b expected 0001", c, fp_rdy); end
            if (c > 0) begin
                n_tests++; if (rr_ov !== 1'b1 || rr_od !== 16'((c - 1) * 16 + (c - 1) % 4)) begin n_fail++; $display("FAIL rr_beat c=%0d: got %b/%h expected 1/%h", c, rr_ov, rr_od, 16'((c - 1) * 16 + (c - 1) % 4)); end
                n_tests++; if (fp_ov !== 1'b1 || fp_od !== 16'((c - 1) * 16)) begin n_fail++; $display("FAIL fp_beat c=%0d: got %b/%h expected 1/%h", c, fp_ov, fp_od, 16'((c - 1) * 16)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        ordy = 1'b0; v = 4'hF;
        for (int k = 0; k < 4; k++) begin d[k] = 16'h0900 + 16'(k); e[k] = 13'sd100; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (rr_rdy !== 4'b0000 || fp_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy i=%0d: got %b/%b expected 0000/0000", i, rr_rdy, fp_rdy); end
            n_tests++; if (rr_ov !== 1'b1 || rr_od !== 16'h0073 || rr_od2 !== -13'sd31) begin n_fail++; $display("FAIL bp_hold_rr i=%0d: got %b/%h/%0d expected 1/0073/-31", i, rr_ov, rr_od, rr_od2); end
            n_tests++; if (fp_ov !== 1'b1 || fp_od !== 16'h0070 || fp_od2 !== -13'sd28) begin n_fail++; $display("FAIL bp_hold_fp i=%0d: got %b/%h/%0d expected 1/0070/-28", i, fp_ov, fp_od, fp_od2); end
            tick();
        end
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = 16'h0A00 + 16'(k);
        @(negedge clk);
        n_tests++; if (rr_od !== 16'h0073 || rr_rdy !== 4'b0001) begin n_fail++; $display("FAIL bp_release: got %h/%b expected 0073/0001", rr_od, rr_rdy); end
        tick();
        @(negedge clk);
        n_tests++; if (rr_ov !== 1'b1 || rr_od !== 16'h0A00) begin n_fail++; $display("FAIL bp_next_rr: got %b/%h expected 1/0a00", rr_ov, rr_od); end
        n_tests++; if (fp_od !== 16'h0A00) begin n_fail++; $display("FAIL bp_next_fp: got %h expected 0a00", fp_od); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; v = 4'hF; ordy = 1'b0;
        d[0] = 16'h5A5A; e[0] = -13'sd4096;
        @(negedge clk);
        n_tests++; if (rr_rdy !== 4'b0000 || fp_rdy !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rdy: got %b/%b expected 0000/0000", rr_rdy, fp_rdy); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (rr_ov !== 1'b0 || rr_od !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_drop: got %b/%h expected 0/0000", rr_ov, rr_od); end
        n_tests++; if (rr_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_in0_first: got %b expected 0001", rr_rdy); end
        tick();
        @(negedge clk);
        n_tests++; if (rr_ov !== 1'b1 || rr_od !== 16'h5A5A || rr_od2 !== -13'sd4096) begin n_fail++; $display("FAIL mid_rst_beat: got %b/%h/%0d expected 1/5a5a/-4096", rr_ov, rr_od, rr_od2); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            v     = 4'($urandom) & 4'($urandom | $urandom);
            ordy  = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                d[k] = 16'($urandom);
                e[k] = 13'($urandom);
            end
            @(negedge clk);
            n_tests++; if (obs_rr !== m_pack(0)) begin n_fail++; $display("FAIL rand_rr c=%0d: got %h expected %h", c, obs_rr, m_pack(0)); end
            n_tests++; if (obs_fp !== m_pack(1)) begin n_fail++; $display("FAIL rand_fp c=%0d: got %h expected %h", c, obs_fp, m_pack(1)); end
            tick();
        end
    endtask

`ifdef STREAM_MERGE4_SRC_ID_EN
    task automatic test_src();
        rst_n = 1'b0; v = 4'b0000; ordy = 1'b1; tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (rr_src !== 2'd0) begin n_fail++; $display("FAIL src_reset: got %0d expected 0", rr_src); end
        v = 4'b1000; d[3] = 16'hC0DE; e[3] = 13'sd33;
        tick();
        v = 4'b0000;
        @(negedge clk);
        n_tests++; if (rr_src !== 2'd3 || rr_od !== 16'hC0DE) begin n_fail++; $display("FAIL src_rr: got %0d/%h expected 3/c0de", rr_src, rr_od); end
        n_tests++; if (fp_src !== 2'd3 || fp_od !== 16'hC0DE) begin n_fail++; $display("FAIL src_fp: got %0d/%h expected 3/c0de", fp_src, fp_od); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; v = 4'b0000; ordy = 1'b0;
        for (int k = 0; k < 4; k++) begin d[k] = '0; e[k] = '0; end
        tick();
        test_reset();
        test_priority();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef STREAM_MERGE4_SRC_ID_EN
        test_src();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
